mem_stage_lsu: RTL and testbench



---
 rtl/mem_stage_lsu_if.sv | 47 ++++
 rtl/mem_stage_lsu.sv | 179 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Bus bundle between the EX/MEM register, the MEM-stage LSU, the data memory and pipe_mem_wb.
// slave = the LSU side, master = the environment driving it.
interface mem_stage_lsu_if;
   logic        in_valid;
   logic        in_mem_rd;
   logic        in_mem_wr;
   logic [1:0]  in_size;
   logic        in_sign_ext;
   logic [31:0] in_alu_result;
   logic [31:0] in_wdata;
   logic [4:0]  in_rd_waddr;
   logic        in_rd_sel;
   logic        in_rd_wena;
   logic        in_dmem_ack;
   logic [31:0] in_dmem_rdata;

   logic        out_dmem_req;
   logic        out_dmem_we;
   logic [31:0] out_dmem_addr;
   logic [3:0]  out_dmem_be;
   logic [31:0] out_dmem_wdata;
   logic        out_stall;
   logic [4:0]  out_rd_waddr;
   logic        out_rd_sel;
   logic        out_rd_wena;
   logic [31:0] out_alu_result;
   logic [31:0] out_dmem_data;
   logic        out_misalign;
   logic        out_bus_err;
   logic [1:0]  dbg_state;

   modport slave (
      input  in_valid, in_mem_rd, in_mem_wr, in_size, in_sign_ext, in_alu_result,
             in_wdata, in_rd_waddr, in_rd_sel, in_rd_wena, in_dmem_ack, in_dmem_rdata,
      output out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_be, out_dmem_wdata,
             out_stall, out_rd_waddr, out_rd_sel, out_rd_wena, out_alu_result,
             out_dmem_data, out_misalign, out_bus_err, dbg_state
   );

   modport master (
      output in_valid, in_mem_rd, in_mem_wr, in_size, in_sign_ext, in_alu_result,
             in_wdata, in_rd_waddr, in_rd_sel, in_rd_wena, in_dmem_ack, in_dmem_rdata,
      input  out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_be, out_dmem_wdata,
             out_stall, out_rd_waddr, out_rd_sel, out_rd_wena, out_alu_result,
             out_dmem_data, out_misalign, out_bus_err, dbg_state
   );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE/WAIT/RESP FSM driving a req/ack data bus with byte lanes.
// Optional abort-on-timeout is enabled with `define LSU_TIMEOUT_EN.
module mem_stage_lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic            in_clk,
   input logic            in_rst,
   mem_stage_lsu_if.slave bus
);
   // Bus handshake: req stays high from WAIT entry until the edge that samples ack=1;
   // addr/we/be/wdata are stable throughout, and ack while req=0 is ignored.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t      state_q, state_d;
   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q, alu_q, cap_q;
   logic [3:0]  be_q;
   logic [4:0]  waddr_q;
   logic        sel_q, wena_q, load_q, sign_q;
   logic [1:0]  size_q, off_q;
   logic        bus_err;

   logic        mem_op, misalign, accept, timeout_hit;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, load_ext;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign mem_op   = bus.in_valid & (bus.in_mem_rd | bus.in_mem_wr);
   assign misalign = mem_op & (((bus.in_size == 2'b01) & bus.in_alu_result[0]) |
                               (bus.in_size[1] & (bus.in_alu_result[1:0] != 2'b00)));
   assign accept   = mem_op & ~misalign;

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = bus.in_wdata;
      case (bus.in_size)
         2'b00: begin
            be_d    = 4'b0001 << bus.in_alu_result[1:0];
            wdata_d = {4{bus.in_wdata[7:0]}};
         end
         2'b01: begin
            be_d    = bus.in_alu_result[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{bus.in_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Lane extraction uses the offset latched at issue, not the live EX/MEM address.
   always_comb begin
      rbyte    = bus.in_dmem_rdata[{off_q, 3'b000} +: 8];
      rhalf    = bus.in_dmem_rdata[{off_q[1], 4'b0000} +: 16];
      load_ext = bus.in_dmem_rdata;
      case (size_q)
         2'b00:   load_ext = sign_q ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
         2'b01:   load_ext = sign_q ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
         default: ;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [7:0] cnt_q;
   assign timeout_hit = (({1'b0, cnt_q} + 9'd1) == 9'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
   assign bus_err     = 1'b0;
`endif

   always_ff @(posedge in_clk) begin
      if (in_rst) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d            = state_q;
      bus.out_rd_waddr   = waddr_q;
      bus.out_rd_sel     = sel_q;
      bus.out_alu_result = alu_q;
      bus.out_rd_wena    = 1'b0;
      bus.out_dmem_data  = 32'd0;
      bus.out_stall      = 1'b0;
      bus.out_misalign   = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.out_rd_waddr   = bus.in_rd_waddr;
            bus.out_rd_sel     = bus.in_rd_sel;
            bus.out_alu_result = bus.in_alu_result;
            bus.out_rd_wena    = bus.in_rd_wena & bus.in_valid & ~mem_op;
            bus.out_misalign   = misalign;
            bus.out_stall      = accept;
            if (accept) state_d = S_WAIT;
         end
         S_WAIT: begin
            bus.out_stall = 1'b1;
            if (bus.in_dmem_ack || timeout_hit) state_d = S_RESP;
         end
         S_RESP: begin
            bus.out_dmem_data = cap_q;
            bus.out_rd_wena   = wena_q & ~bus_err;
            state_d           = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         alu_q   <= 32'd0;
         waddr_q <= 5'd0;
         sel_q   <= 1'b0;
         wena_q  <= 1'b0;
         load_q  <= 1'b0;
         sign_q  <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= 2'd0;
         cap_q   <= 32'd0;
`ifdef LSU_TIMEOUT_EN
         cnt_q   <= 8'd0;
         bus_err <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               req_q   <= 1'b1;
               we_q    <= bus.in_mem_wr;
               addr_q  <= {bus.in_alu_result[31:2], 2'b00};
               be_q    <= be_d;
               wdata_q <= wdata_d;
               alu_q   <= bus.in_alu_result;
               waddr_q <= bus.in_rd_waddr;
               sel_q   <= bus.in_rd_sel;
               wena_q  <= bus.in_rd_wena;
               load_q  <= bus.in_mem_rd;
               sign_q  <= bus.in_sign_ext;
               size_q  <= bus.in_size;
               off_q   <= bus.in_alu_result[1:0];
`ifdef LSU_TIMEOUT_EN
               cnt_q   <= 8'd0;
`endif
            end
            S_WAIT: begin
               if (bus.in_dmem_ack) begin
                  req_q <= 1'b0;
                  cap_q <= load_q ? load_ext : 32'd0;
               end
`ifdef LSU_TIMEOUT_EN
               else if (timeout_hit) begin
                  req_q   <= 1'b0;
                  cap_q   <= 32'd0;
                  bus_err <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
`endif
            end
            S_RESP: begin
`ifdef LSU_TIMEOUT_EN
               bus_err <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.out_dmem_req   = req_q;
   assign bus.out_dmem_we    = we_q;
   assign bus.out_dmem_addr  = addr_q;
   assign bus.out_dmem_be    = be_q;
   assign bus.out_dmem_wdata = wdata_q;
   assign bus.out_bus_err    = bus_err;
   assign bus.dbg_state      = state_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: non-memory pass-through, loads/stores, misalignment,
// reset during WAIT and (with LSU_TIMEOUT_EN) the timeout abort.
module tb_mem_stage_lsu;
   localparam logic [31:0] ST_IDLE = 32'd0;
   localparam logic [31:0] ST_WAIT = 32'd1;
   localparam logic [31:0] ST_RESP = 32'd2;

   logic in_clk;
   logic in_rst;
   int   checks;
   int   errors;
   logic [31:0] exp_q[$];
   logic [31:0] exp_data;

   mem_stage_lsu_if bus ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .in_clk (in_clk),
      .in_rst (in_rst),
      .bus    (bus.slave)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic step;
      @(posedge in_clk);
      #1;
   endtask

   task automatic sample;
      @(negedge in_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic drive_op(input logic valid, input logic rd, input logic wr,
                           input logic [1:0] size, input logic sign,
                           input logic [31:0] alu, input logic [31:0] wdata,
                           input logic [4:0] waddr, input logic sel, input logic wena);
      bus.in_valid      = valid;
      bus.in_mem_rd     = rd;
      bus.in_mem_wr     = wr;
      bus.in_size       = size;
      bus.in_sign_ext   = sign;
      bus.in_alu_result = alu;
      bus.in_wdata      = wdata;
      bus.in_rd_waddr   = waddr;
      bus.in_rd_sel     = sel;
      bus.in_rd_wena    = wena;
   endtask

   task automatic drive_idle;
      drive_op(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
   endtask

   // Load with ack on the first req cycle; expected value taken from exp_q.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic sign, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [4:0] waddr);
      step;
      drive_op(1'b1, 1'b1, 1'b0, size, sign, addr, 32'd0, waddr, 1'b0, 1'b1);
      sample;
      chk({tag, "_c0_stall"}, 32'(bus.out_stall), 32'd1);
      chk({tag, "_c0_wena"}, 32'(bus.out_rd_wena), 32'd0);
      chk({tag, "_c0_req"}, 32'(bus.out_dmem_req), 32'd0);
      step;
      sample;
      chk({tag, "_c1_state"}, 32'(bus.dbg_state), ST_WAIT);
      chk({tag, "_c1_req"}, 32'(bus.out_dmem_req), 32'd1);
      chk({tag, "_c1_we"}, 32'(bus.out_dmem_we), 32'd0);
      chk({tag, "_c1_addr"}, bus.out_dmem_addr, exp_addr);
      chk({tag, "_c1_be"}, 32'(bus.out_dmem_be), 32'(exp_be));
      chk({tag, "_c1_stall"}, 32'(bus.out_stall), 32'd1);
      chk({tag, "_c1_wena"}, 32'(bus.out_rd_wena), 32'd0);
      bus.in_dmem_ack   = 1'b1;
      bus.in_dmem_rdata = rdata;
      step;
      bus.in_dmem_ack   = 1'b0;
      bus.in_dmem_rdata = 32'd0;
      sample;
      exp_data = exp_q.pop_front();
      chk({tag, "_c2_state"}, 32'(bus.dbg_state), ST_RESP);
      chk({tag, "_c2_stall"}, 32'(bus.out_stall), 32'd0);
      chk({tag, "_c2_req"}, 32'(bus.out_dmem_req), 32'd0);
      chk({tag, "_c2_data"}, bus.out_dmem_data, exp_data);
      chk({tag, "_c2_wena"}, 32'(bus.out_rd_wena), 32'd1);
      chk({tag, "_c2_waddr"}, 32'(bus.out_rd_waddr), 32'(waddr));
      chk({tag, "_c2_alu"}, bus.out_alu_result, addr);
      step;
      drive_idle();
      sample;
      chk({tag, "_c3_state"}, 32'(bus.dbg_state), ST_IDLE);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      in_rst = 1'b1;
      drive_idle();
      bus.in_dmem_ack   = 1'b0;
      bus.in_dmem_rdata = 32'd0;
      repeat (2) @(posedge in_clk);
      sample;
      chk("rst_state", 32'(bus.dbg_state), ST_IDLE);
      chk("rst_req", 32'(bus.out_dmem_req), 32'd0);
      chk("rst_be", 32'(bus.out_dmem_be), 32'd0);
      chk("rst_addr", bus.out_dmem_addr, 32'd0);
      chk("rst_stall", 32'(bus.out_stall), 32'd0);
      chk("rst_bus_err", 32'(bus.out_bus_err), 32'd0);
      step;
      in_rst = 1'b0;

      // Non-memory op passes through combinationally
      drive_op(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b1);
      sample;
      chk("nm_waddr", 32'(bus.out_rd_waddr), 32'd5);
      chk("nm_wena", 32'(bus.out_rd_wena), 32'd1);
      chk("nm_sel", 32'(bus.out_rd_sel), 32'd1);
      chk("nm_alu", bus.out_alu_result, 32'h0000_1234);
      chk("nm_stall", 32'(bus.out_stall), 32'd0);
      chk("nm_data", bus.out_dmem_data, 32'd0);
      step;
      sample;
      chk("nm_req", 32'(bus.out_dmem_req), 32'd0);
      chk("nm_state", 32'(bus.dbg_state), ST_IDLE);
      bus.in_valid = 1'b0;
      sample;
      chk("nm_invalid_wena", 32'(bus.out_rd_wena), 32'd0);

      // Loads: signed byte at lane 3, unsigned half at upper lane, signed half, word
      exp_q.push_back(32'hFFFF_FF80);
      do_load("lb", 32'h0000_0103, 2'b00, 1'b1, 32'h80FF_FF00, 32'h0000_0100, 4'b1000, 5'd7);
      exp_q.push_back(32'h0000_8765);
      do_load("lhu", 32'h0000_0002, 2'b01, 1'b0, 32'h8765_4321, 32'h0000_0000, 4'b1100, 5'd9);
      exp_q.push_back(32'hFFFF_9ABC);
      do_load("lh", 32'h0000_0010, 2'b01, 1'b1, 32'h1234_9ABC, 32'h0000_0010, 4'b0011, 5'd3);
      exp_q.push_back(32'h0000_007F);
      do_load("lbu", 32'h0000_0021, 2'b00, 1'b0, 32'hFF00_7FFF, 32'h0000_0020, 4'b0010, 5'd4);
      exp_q.push_back(32'hDEAD_BEEF);
      do_load("lw", 32'h0000_0044, 2'b10, 1'b1, 32'hDEAD_BEEF, 32'h0000_0044, 4'b1111, 5'd11);

      // Store half with three extra wait cycles
      step;
      drive_op(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0);
      exp_q.push_back(32'd0);
      sample;
      chk("sh_c0_stall", 32'(bus.out_stall), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step;
         sample;
         chk("sh_req", 32'(bus.out_dmem_req), 32'd1);
         chk("sh_we", 32'(bus.out_dmem_we), 32'd1);
         chk("sh_be", 32'(bus.out_dmem_be), 32'hC);
         chk("sh_addr", bus.out_dmem_addr, 32'h0000_0020);
         chk("sh_wdata", bus.out_dmem_wdata, 32'hABCD_ABCD);
         chk("sh_stall", 32'(bus.out_stall), 32'd1);
         if (i == 3) bus.in_dmem_ack = 1'b1;
      end
      step;
      bus.in_dmem_ack = 1'b0;
      sample;
      exp_data = exp_q.pop_front();
      chk("sh_resp_state", 32'(bus.dbg_state), ST_RESP);
      chk("sh_resp_data", bus.out_dmem_data, exp_data);
      chk("sh_resp_req", 32'(bus.out_dmem_req), 32'd0);
      chk("sh_resp_stall", 32'(bus.out_stall), 32'd0);
      step;
      drive_idle();

      // Misaligned accesses: no request, no stall
      step;
      drive_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0041, 32'd0, 5'd6, 1'b0, 1'b1);
      sample;
      chk("mis_w_flag", 32'(bus.out_misalign), 32'd1);
      chk("mis_w_wena", 32'(bus.out_rd_wena), 32'd0);
      chk("mis_w_stall", 32'(bus.out_stall), 32'd0);
      step;
      sample;
      chk("mis_w_req", 32'(bus.out_dmem_req), 32'd0);
      chk("mis_w_state", 32'(bus.dbg_state), ST_IDLE);
      bus.in_size = 2'b01;
      bus.in_alu_result = 32'h0000_0033;
      #1;
      chk("mis_h_flag", 32'(bus.out_misalign), 32'd1);
      bus.in_size = 2'b11;
      bus.in_alu_result = 32'h0000_0002;
      #1;
      chk("mis_s11_flag", 32'(bus.out_misalign), 32'd1);
      bus.in_size = 2'b00;
      bus.in_alu_result = 32'h0000_0003;
      #1;
      chk("byte_not_mis", 32'(bus.out_misalign), 32'd0);
      chk("byte_stall", 32'(bus.out_stall), 32'd1);
      bus.in_valid = 1'b0;
      step;

      // Reset in the second WAIT cycle abandons the load
      drive_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'd0, 5'd8, 1'b0, 1'b1);
      step;
      sample;
      chk("rw_w1_req", 32'(bus.out_dmem_req), 32'd1);
      step;
      sample;
      chk("rw_w2_req", 32'(bus.out_dmem_req), 32'd1);
      in_rst = 1'b1;
      bus.in_valid = 1'b0;
      step;
      sample;
      chk("rw_rst_req", 32'(bus.out_dmem_req), 32'd0);
      chk("rw_rst_stall", 32'(bus.out_stall), 32'd0);
      chk("rw_rst_state", 32'(bus.dbg_state), ST_IDLE);
      in_rst = 1'b0;
      bus.in_dmem_ack = 1'b1;
      bus.in_dmem_rdata = 32'hFFFF_FFFF;
      step;
      sample;
      chk("rw_ack_state", 32'(bus.dbg_state), ST_IDLE);
      chk("rw_ack_req", 32'(bus.out_dmem_req), 32'd0);
      chk("rw_ack_data", bus.out_dmem_data, 32'd0);
      chk("rw_ack_wena", 32'(bus.out_rd_wena), 32'd0);
      bus.in_dmem_ack = 1'b0;
      bus.in_dmem_rdata = 32'd0;

`ifdef LSU_TIMEOUT_EN
      // No ack: four req cycles, then RESP with bus error
      step;
      drive_op(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0, 5'd12, 1'b0, 1'b1);
      sample;
      chk("to_c0_stall", 32'(bus.out_stall), 32'd1);
      for (int i = 0; i < 4; i++) begin
         step;
         sample;
         chk("to_req", 32'(bus.out_dmem_req), 32'd1);
         chk("to_bus_err_wait", 32'(bus.out_bus_err), 32'd0);
      end
      step;
      sample;
      chk("to_resp_state", 32'(bus.dbg_state), ST_RESP);
      chk("to_resp_err", 32'(bus.out_bus_err), 32'd1);
      chk("to_resp_wena", 32'(bus.out_rd_wena), 32'd0);
      chk("to_resp_data", bus.out_dmem_data, 32'd0);
      chk("to_resp_req", 32'(bus.out_dmem_req), 32'd0);
      bus.in_valid = 1'b0;
      step;
      sample;
      chk("to_idle_state", 32'(bus.dbg_state), ST_IDLE);
      chk("to_idle_err", 32'(bus.out_bus_err), 32'd0);
`else
      chk("no_to_bus_err", 32'(bus.out_bus_err), 32'd0);
`endif

      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
